// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the FIFO write-side logic.
//   arb_state_t  : state encoding of the write-port arbiter
//   rr_next_idx  : round-robin search, returns the first set bit of req strictly
//                  after index 'last', wrapping circularly over n entries
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Upper bound on the number of requesters the search helper handles.
    localparam int unsigned RR_MAX_REQ = 32'd32;

    // Scans last+1, last+2, ... (mod n) and returns the first index with req set.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic int unsigned rr_next_idx(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           last,
        input int unsigned           n
    );
        int unsigned idx;
        int unsigned cand;
        logic        found;
        idx   = 32'd0;
        found = 1'b0;
        for (int unsigned k = 32'd1; k <= RR_MAX_REQ; k++) begin
            cand = last + k;
            if (cand >= n) begin
                cand = cand - n;
            end else begin
                cand = cand;
            end
            if ((k <= n) && !found && req[cand[4:0]]) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   last : index of the previous winner; the search starts just after it
//   idx  : winning index (meaningful only when any=1)
//   any  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [RR_MAX_REQ-1:0] req_ext_s;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext_s                = '0;
        req_ext_s[NUM_REQ-1:0]   = req;
        idx = IDX_W'(rr_next_idx(req_ext_s, 32'(last), 32'(NUM_REQ)));
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the FIFO write port between NUM_REQ requesters in the wclk domain.
// Round-robin grants, at most MAX_BURST words per grant, one idle bubble
// between grants. wfull stalls the current grant without ending it.
//   wclk, wrst_n : write clock, asynchronous active-low reset
//   req_valid    : per-requester word available
//   req_data     : packed words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : one-hot or zero; word i taken when valid[i] && ready[i]
//   wfull        : FIFO full, backpressure
//   winc         : write strobe to memory enable and write pointer
//   wdata        : write word to memory
//   grant_id     : currently (or most recently) granted requester
//   busy         : a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

    arb_state_t              state_r;
    arb_state_t              state_nxt_s;
    logic [IDX_W-1:0]        grant_id_r;
    logic [IDX_W-1:0]        grant_id_nxt_s;
    logic [CNT_W-1:0]        burst_cnt_r;
    logic [CNT_W-1:0]        burst_cnt_nxt_s;
    logic [IDX_W-1:0]        last_winner_r;
    logic [IDX_W-1:0]        last_winner_nxt_s;

    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_any_s;
    logic                    sel_valid_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    xfer_s;
    logic                    leave_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req  (req_valid),
        .last (last_winner_r),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Select the granted requester's valid and word.
    always_comb begin
        sel_valid_s = req_valid[grant_id_r];
        sel_data_s  = req_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
    end

    // Output decode: everything here depends only on registered state and wfull
    // (plus the granted valid), so a full FIFO can never see a write strobe.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        busy      = 1'b0;
        xfer_s    = 1'b0;
        leave_s   = 1'b0;
        case (state_r)
            ARB_GRANT: begin
                busy                  = 1'b1;
                req_ready[grant_id_r] = !wfull;
                xfer_s                = sel_valid_s && !wfull;
                winc                  = xfer_s;
                wdata                 = sel_data_s;
                // Burst exhausted, or the requester went away while the FIFO could
                // have accepted; under wfull the grant is simply held.
                leave_s = (xfer_s && (burst_cnt_r == BURST_LAST)) ||
                          (!sel_valid_s && !wfull);
            end
            ARB_IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Next-state logic for the FSM, grant index, burst counter and last winner.
    always_comb begin
        state_nxt_s       = state_r;
        grant_id_nxt_s    = grant_id_r;
        burst_cnt_nxt_s   = burst_cnt_r;
        last_winner_nxt_s = last_winner_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s     = ARB_GRANT;
                    grant_id_nxt_s  = pick_idx_s;
                    burst_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s     = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                burst_cnt_nxt_s = xfer_s ? (burst_cnt_r + CNT_W'(1)) : burst_cnt_r;
                if (leave_s) begin
                    state_nxt_s       = ARB_IDLE;
                    last_winner_nxt_s = grant_id_r;
                end else begin
                    state_nxt_s       = ARB_GRANT;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State registers; last_winner resets to the top index so requester 0 wins first.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r       <= ARB_IDLE;
            grant_id_r    <= '0;
            burst_cnt_r   <= '0;
            last_winner_r <= LAST_RST;
        end else begin
            state_r       <= state_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            burst_cnt_r   <= burst_cnt_nxt_s;
            last_winner_r <= last_winner_nxt_s;
        end
    end

    assign grant_id = grant_id_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (DATA_WIDTH=8, NUM_REQ=4, MAX_BURST=4).
// Requester i offers words {i[1:0], seq[5:0]} with an incrementing sequence.
// A behavioural model of the arbitration rules predicts all outputs each cycle;
// directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic            wclk;
    logic            wrst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_run  = 0;
    int n_fail = 0;

    // requester-side state
    int  rem [NR];
    int  seq [NR];
    bit  acc [NR];
    int  rnd_mode;

    // model state
    int  m_owner;
    int  m_gid;
    int  m_cnt;
    int  m_last;
    int  exp_seq [NR];

    // observation
    int  grant_log [$];
    int  wcnt;
    bit  prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_of(input int src, input int s);
        logic [31:0] w;
        w = (src << 6) | (s % 64);
        return w[7:0];
    endfunction

    // Per-cycle comparison against the model, then model advance.
    always @(negedge wclk) begin
        logic        e_busy;
        logic [3:0]  e_ready;
        logic        e_winc;
        logic [7:0]  e_wdata;
        int          e_gid;
        if (!wrst_n) begin
            chk("rst_winc", {31'd0, winc}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ready", {28'd0, req_ready}, 32'd0);
            chk("rst_gid", {30'd0, grant_id}, 32'd0);
            m_owner   = -1;
            m_gid     = 0;
            m_cnt     = 0;
            m_last    = NR - 1;
            prev_busy = 1'b0;
        end else begin
            if (m_owner < 0) begin
                e_busy  = 1'b0;
                e_ready = 4'd0;
                e_winc  = 1'b0;
                e_wdata = 8'd0;
                e_gid   = m_gid;
            end else begin
                e_busy  = 1'b1;
                e_ready = wfull ? 4'd0 : (4'd1 << m_owner);
                e_winc  = req_valid[m_owner] && !wfull;
                e_wdata = req_data[m_owner*DW +: DW];
                e_gid   = m_owner;
            end
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("req_ready", {28'd0, req_ready}, {28'd0, e_ready});
            chk("winc", {31'd0, winc}, {31'd0, e_winc});
            chk("wdata", {24'd0, wdata}, {24'd0, e_wdata});
            chk("grant_id", {30'd0, grant_id}, 32'(e_gid));
            chk("winc_while_full", {31'd0, winc & wfull}, 32'd0);
            if (e_winc) begin
                chk("sb_word", {24'd0, wdata}, {24'd0, word_of(m_owner, exp_seq[m_owner])});
            end
            if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
            prev_busy = busy;
            if (winc) wcnt++;
            // advance the model by one clock
            if (m_owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (m_owner < 0 && req_valid[(m_last + k) % NR]) begin
                        m_owner = (m_last + k) % NR;
                    end
                end
                if (m_owner >= 0) begin
                    m_gid = m_owner;
                    m_cnt = 0;
                end
            end else begin
                if (e_winc) begin
                    m_cnt++;
                    exp_seq[m_owner]++;
                    acc[m_owner] = 1'b1;
                end
                if ((e_winc && m_cnt == MB) || (!req_valid[m_owner] && !wfull)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    // One clock for the requesters: retire accepted words, then re-drive.
    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            logic nv;
            if (acc[i]) begin
                acc[i] = 1'b0;
                seq[i]++;
                if (rnd_mode == 0 && rem[i] > 0) rem[i]--;
                nv = (rnd_mode == 1) ? ($urandom_range(0, 1) == 1) :
                     (rnd_mode == 0) ? (rem[i] > 0) : 1'b0;
            end else begin
                nv = (rnd_mode == 1) ? (req_valid[i] | ($urandom_range(0, 1) == 1)) :
                     (rnd_mode == 0) ? (rem[i] > 0) : req_valid[i];
            end
            req_valid[i]          = nv;
            req_data[i*DW +: DW]  = word_of(i, seq[i]);
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        wrst_n    = 1'b0;
        wfull     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rnd_mode  = 0;
        wcnt      = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; seq[i] = 0; acc[i] = 1'b0; exp_seq[i] = 0;
        end
        m_owner = -1; m_gid = 0; m_cnt = 0; m_last = NR - 1; prev_busy = 1'b0;
        run(3);
        wrst_n = 1'b1;
        step();
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_gid", {30'd0, grant_id}, 32'd0);

        // reset in the middle of a burst
        rem[1] = 3;
        step();
        step();
        #1;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_gid", {30'd0, grant_id}, 32'd1);
        chk("t1_winc", {31'd0, winc}, 32'd1);
        wrst_n = 1'b0;
        #1;
        chk("t1_rst_winc", {31'd0, winc}, 32'd0);
        chk("t1_rst_busy", {31'd0, busy}, 32'd0);
        chk("t1_rst_ready", {28'd0, req_ready}, 32'd0);
        rem[0] = 2;
        step();
        step();
        grant_log.delete();
        wrst_n = 1'b1;
        run(15);
        chk("t1_log_size", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("t1_first", 32'(grant_log[0]), 32'd0);
            chk("t1_second", 32'(grant_log[1]), 32'd1);
        end

        // last winner 1, requesters 1 and 3 -> 3 then 1
        grant_log.delete();
        rem[1] = 1; rem[3] = 1;
        run(10);
        chk("t5_log_size", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("t5_first", 32'(grant_log[0]), 32'd3);
            chk("t5_second", 32'(grant_log[1]), 32'd1);
        end

        // single requester 2 sends two words then drops valid
        grant_log.delete();
        wcnt = 0;
        rem[2] = 2;
        run(6);
        chk("t3_wincs", 32'(wcnt), 32'd2);
        chk("t3_log0", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        // last winner now 2: requesters 0 and 3 -> 3 first
        grant_log.delete();
        rem[0] = 1; rem[3] = 1;
        run(10);
        chk("t3_next", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd3);
        // single word from 3 leaves last winner at 3
        rem[3] = 1;
        run(6);

        // all four requesters, full bursts in round-robin order
        grant_log.delete();
        wcnt = 0;
        for (int i = 0; i < NR; i++) rem[i] = 8;
        run(50);
        chk("t2_wincs", 32'(wcnt), 32'd32);
        chk("t2_grants", 32'(grant_log.size()), 32'd8);
        for (int g = 0; g < 5; g++) begin
            if (g < grant_log.size()) chk("t2_order", 32'(grant_log[g]), 32'(g % NR));
        end

        // wfull held for five cycles at burst count 2
        rem[0] = 6;
        step();
        step();
        #1;
        chk("t4_first_winc", {31'd0, winc}, 32'd1);
        step();
        step();
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_hold_winc", {31'd0, winc}, 32'd0);
            chk("t4_hold_busy", {31'd0, busy}, 32'd1);
            chk("t4_hold_gid", {30'd0, grant_id}, 32'd0);
            step();
        end
        wfull = 1'b0;
        #1;
        chk("t4_resume1", {31'd0, winc}, 32'd1);
        step();
        #1;
        chk("t4_resume2", {31'd0, winc}, 32'd1);
        step();
        #1;
        chk("t4_bubble", {31'd0, busy}, 32'd0);
        run(10);

        // random valid/wfull traffic, then drain with the FIFO open
        rnd_mode = 1;
        for (int c = 0; c < 10000; c++) begin
            wfull = ($urandom_range(0, 3) == 0);
            step();
        end
        wfull    = 1'b0;
        rnd_mode = 2;
        run(40);
        #1;
        chk("t6_drained_valid", {28'd0, req_valid}, 32'd0);
        chk("t6_drained_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
